spio_hss_multiplexer_frame_disassembler: RTL and testbench

- Receive-side stage directly upstream of the packet dispatcher.
- Parses the 32-bit word stream from the HSS receiver into frames, buffers up to NUM_CHANS packets per frame, checks the trailer, then presents all packets together with the frame colour/sequence in a single cycle.
- Also decodes out-of-credit (OOC) frames and reports framing/CRC errors to the register bank.

---
 rtl/spio_hss_multiplexer_frame_disassembler_pkg.sv | 34 +++
 rtl/spio_hss_multiplexer_crc16.sv | 21 ++
 rtl/spio_hss_multiplexer_frame_disassembler.sv | 252 +++++++++++++++++++++++++
 tb/tb_spio_hss_multiplexer_frame_disassembler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spio_hss_multiplexer_frame_disassembler_pkg.sv
// Shared constants, state encoding and helpers for the HSS multiplexer receive path.
package spio_hss_multiplexer_frame_disassembler_pkg;

  localparam int PKT_BITS  = 72;
  localparam int SEQ_BITS  = 7;
  localparam int CLR_BITS  = 1;
  localparam int NUM_CHANS = 8;

  localparam logic [7:0] FRM_TYPE_DATA = 8'h00;
  localparam logic [7:0] FRM_TYPE_OOC  = 8'h01;
  localparam logic [7:0] SOF_CODE_DEF  = 8'hBC;
  localparam logic [7:0] EOF_CODE_DEF  = 8'hFD;
  localparam logic [3:0] SOF_KCHR      = 4'b0001;
  localparam logic [3:0] EOF_KCHR      = 4'b1000;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PKT,
    ST_TRL,
    ST_DROP
  } rx_state_e;

  // Index of the lowest set bit; callers only use it when the vector is non-zero.
  function automatic logic [2:0] lowest_set(input logic [NUM_CHANS-1:0] v);
    lowest_set = 3'd0;
    for (int i = NUM_CHANS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/spio_hss_multiplexer_crc16.sv
// Combinational CRC-16-CCITT update over one 32-bit word, bit 31 shifted in first.
module spio_hss_multiplexer_crc16
  import spio_hss_multiplexer_frame_disassembler_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [31:0] data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 31; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/spio_hss_multiplexer_frame_disassembler.sv
// Parses HSS receive words into frames and commits all packets of a frame in one cycle.
// Trailer CRC checking is built only when SPIO_HSS_MULTIPLEXER_RX_CRC_EN is defined.
module spio_hss_multiplexer_frame_disassembler
  import spio_hss_multiplexer_frame_disassembler_pkg::*;
#(
  parameter logic [7:0] SOF_CODE = SOF_CODE_DEF,
  parameter logic [7:0] EOF_CODE = EOF_CODE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         hsl_data,
  input  logic [3:0]          hsl_kchr,
  input  logic                hsl_vld,
  output logic [PKT_BITS-1:0] ipkt_data0,
  output logic [PKT_BITS-1:0] ipkt_data1,
  output logic [PKT_BITS-1:0] ipkt_data2,
  output logic [PKT_BITS-1:0] ipkt_data3,
  output logic [PKT_BITS-1:0] ipkt_data4,
  output logic [PKT_BITS-1:0] ipkt_data5,
  output logic [PKT_BITS-1:0] ipkt_data6,
  output logic [PKT_BITS-1:0] ipkt_data7,
  output logic                ipkt_vld0,
  output logic                ipkt_vld1,
  output logic                ipkt_vld2,
  output logic                ipkt_vld3,
  output logic                ipkt_vld4,
  output logic                ipkt_vld5,
  output logic                ipkt_vld6,
  output logic                ipkt_vld7,
  output logic [CLR_BITS-1:0] frm_colour,
  output logic [SEQ_BITS-1:0] frm_seq,
  output logic                frm_vld,
  output logic [CLR_BITS-1:0] ooc_colour,
  output logic                ooc_vld,
  output logic                reg_frme,
  output logic                reg_crce
);

  rx_state_e            state_q, state_d;
  logic [NUM_CHANS-1:0] rem_q, rem_d, bmp_q, bmp_d, rem_clr;
  logic [SEQ_BITS-1:0]  seq_q, seq_d, frm_seq_q, frm_seq_d;
  logic [CLR_BITS-1:0]  colour_q, colour_d, frm_colour_q, frm_colour_d;
  logic [CLR_BITS-1:0]  ooc_colour_q, ooc_colour_d;
  logic                 ooc_q, ooc_d;
  logic [2:0]           chan_q, chan_d;
  logic [1:0]           wcnt_q, wcnt_d;
  logic [PKT_BITS-1:0]  hold_q [NUM_CHANS];
  logic [PKT_BITS-1:0]  hold_d [NUM_CHANS];
  logic [PKT_BITS-1:0]  out_data_q [NUM_CHANS];
  logic [PKT_BITS-1:0]  out_data_d [NUM_CHANS];
  logic [NUM_CHANS-1:0] out_vld_q, out_vld_d;
  logic                 frm_vld_q, frm_vld_d, ooc_vld_q, ooc_vld_d;
  logic                 frme_q, frme_d, crce_q, crce_d;
  logic                 sof_word, trl_ok, crc_ok;
  logic [7:0]           hdr_type;
  logic [NUM_CHANS-1:0] hdr_bmp;

  assign sof_word = (hsl_kchr == SOF_KCHR) && (hsl_data[7:0] == SOF_CODE);
  assign trl_ok   = (hsl_kchr == EOF_KCHR) && (hsl_data[31:24] == EOF_CODE) &&
                    (hsl_data[23:16] == 8'h00);
  assign hdr_type = hsl_data[31:24];
  assign hdr_bmp  = hsl_data[15:8];
  assign rem_clr  = rem_q & ~(NUM_CHANS'(1) << chan_q);

`ifdef SPIO_HSS_MULTIPLEXER_RX_CRC_EN
  logic [15:0] crc_q, crc_d, crc_seed, crc_next;

  // A header always restarts the accumulator, even when it aborts a frame in flight.
  assign crc_seed = sof_word ? CRC_INIT : crc_q;
  assign crc_ok   = (hsl_data[15:0] == crc_q);

  spio_hss_multiplexer_crc16 u_crc16 (
    .crc_in  (crc_seed),
    .data    (hsl_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    bmp_d        = bmp_q;
    seq_d        = seq_q;
    colour_d     = colour_q;
    ooc_d        = ooc_q;
    chan_d       = chan_q;
    wcnt_d       = wcnt_q;
    hold_d       = hold_q;
    out_data_d   = out_data_q;
    frm_seq_d    = frm_seq_q;
    frm_colour_d = frm_colour_q;
    ooc_colour_d = ooc_colour_q;
    out_vld_d    = '0;
    frm_vld_d    = 1'b0;
    ooc_vld_d    = 1'b0;
    frme_d       = 1'b0;
    crce_d       = 1'b0;
`ifdef SPIO_HSS_MULTIPLEXER_RX_CRC_EN
    crc_d        = crc_q;
`endif
    if (hsl_vld) begin
      if (sof_word) begin
        // Leaving DROP on a SOF is the normal resync path, not a second error.
        if (state_q == ST_PKT || state_q == ST_TRL) frme_d = 1'b1;
        seq_d    = hsl_data[22:16];
        colour_d = CLR_BITS'(hsl_data[23]);
        bmp_d    = hdr_bmp;
        rem_d    = hdr_bmp;
        chan_d   = lowest_set(hdr_bmp);
        wcnt_d   = 2'd0;
        ooc_d    = (hdr_type == FRM_TYPE_OOC);
`ifdef SPIO_HSS_MULTIPLEXER_RX_CRC_EN
        crc_d    = crc_next;
`endif
        if (hdr_type == FRM_TYPE_DATA) begin
          state_d = (hdr_bmp != '0) ? ST_PKT : ST_TRL;
        end else if (hdr_type == FRM_TYPE_OOC && hdr_bmp == '0) begin
          state_d = ST_TRL;
        end else begin
          frme_d  = 1'b1;
          state_d = ST_DROP;
        end
      end else begin
        case (state_q)
          ST_PKT: begin
            if (hsl_kchr != 4'b0000) begin
              frme_d  = 1'b1;
              state_d = ST_DROP;
            end else begin
`ifdef SPIO_HSS_MULTIPLEXER_RX_CRC_EN
              crc_d = crc_next;
`endif
              case (wcnt_q)
                2'd0: begin
                  hold_d[chan_q][31:0] = hsl_data;
                  wcnt_d = 2'd1;
                end
                2'd1: begin
                  hold_d[chan_q][63:32] = hsl_data;
                  wcnt_d = 2'd2;
                end
                default: begin
                  hold_d[chan_q][71:64] = hsl_data[7:0];
                  wcnt_d = 2'd0;
                  rem_d  = rem_clr;
                  chan_d = lowest_set(rem_clr);
                  if (rem_clr == '0) state_d = ST_TRL;
                end
              endcase
            end
          end
          ST_TRL: begin
            state_d = ST_IDLE;
            if (!trl_ok) begin
              frme_d = 1'b1;
            end else if (!crc_ok) begin
              crce_d = 1'b1;
            end else if (ooc_q) begin
              ooc_vld_d    = 1'b1;
              ooc_colour_d = colour_q;
            end else begin
              frm_vld_d    = 1'b1;
              frm_seq_d    = seq_q;
              frm_colour_d = colour_q;
              out_vld_d    = bmp_q;
              for (int i = 0; i < NUM_CHANS; i++) begin
                if (bmp_q[i]) out_data_d[i] = hold_q[i];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      bmp_q        <= '0;
      seq_q        <= '0;
      colour_q     <= '0;
      ooc_q        <= 1'b0;
      chan_q       <= '0;
      wcnt_q       <= '0;
      frm_seq_q    <= '0;
      frm_colour_q <= '0;
      ooc_colour_q <= '0;
      out_vld_q    <= '0;
      frm_vld_q    <= 1'b0;
      ooc_vld_q    <= 1'b0;
      frme_q       <= 1'b0;
      crce_q       <= 1'b0;
      for (int i = 0; i < NUM_CHANS; i++) begin
        hold_q[i]     <= '0;
        out_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      bmp_q        <= bmp_d;
      seq_q        <= seq_d;
      colour_q     <= colour_d;
      ooc_q        <= ooc_d;
      chan_q       <= chan_d;
      wcnt_q       <= wcnt_d;
      frm_seq_q    <= frm_seq_d;
      frm_colour_q <= frm_colour_d;
      ooc_colour_q <= ooc_colour_d;
      out_vld_q    <= out_vld_d;
      frm_vld_q    <= frm_vld_d;
      ooc_vld_q    <= ooc_vld_d;
      frme_q       <= frme_d;
      crce_q       <= crce_d;
      hold_q       <= hold_d;
      out_data_q   <= out_data_d;
    end
  end

  assign ipkt_data0 = out_data_q[0];
  assign ipkt_data1 = out_data_q[1];
  assign ipkt_data2 = out_data_q[2];
  assign ipkt_data3 = out_data_q[3];
  assign ipkt_data4 = out_data_q[4];
  assign ipkt_data5 = out_data_q[5];
  assign ipkt_data6 = out_data_q[6];
  assign ipkt_data7 = out_data_q[7];
  assign ipkt_vld0  = out_vld_q[0];
  assign ipkt_vld1  = out_vld_q[1];
  assign ipkt_vld2  = out_vld_q[2];
  assign ipkt_vld3  = out_vld_q[3];
  assign ipkt_vld4  = out_vld_q[4];
  assign ipkt_vld5  = out_vld_q[5];
  assign ipkt_vld6  = out_vld_q[6];
  assign ipkt_vld7  = out_vld_q[7];
  assign frm_colour = frm_colour_q;
  assign frm_seq    = frm_seq_q;
  assign frm_vld    = frm_vld_q;
  assign ooc_colour = ooc_colour_q;
  assign ooc_vld    = ooc_vld_q;
  assign reg_frme   = frme_q;
  assign reg_crce   = crce_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_frame_disassembler.sv
// Directed bench for the HSS frame disassembler; CRC expectations follow SPIO_HSS_MULTIPLEXER_RX_CRC_EN.
module tb_spio_hss_multiplexer_frame_disassembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] hsl_data = '0;
  logic [3:0]  hsl_kchr = '0;
  logic        hsl_vld = 1'b0;
  logic [71:0] ipkt_data [8];
  logic [7:0]  ipkt_vld;
  logic        frm_colour, frm_vld, ooc_colour, ooc_vld, reg_frme, reg_crce;
  logic [6:0]  frm_seq;

  int          checks = 0;
  int          failures = 0;
  logic [71:0] pkts [8];
  logic [15:0] run_crc = 16'hFFFF;

  always #5 clk = ~clk;

  spio_hss_multiplexer_frame_disassembler dut (
    .clk(clk), .rst(rst), .hsl_data(hsl_data), .hsl_kchr(hsl_kchr), .hsl_vld(hsl_vld),
    .ipkt_data0(ipkt_data[0]), .ipkt_data1(ipkt_data[1]), .ipkt_data2(ipkt_data[2]),
    .ipkt_data3(ipkt_data[3]), .ipkt_data4(ipkt_data[4]), .ipkt_data5(ipkt_data[5]),
    .ipkt_data6(ipkt_data[6]), .ipkt_data7(ipkt_data[7]),
    .ipkt_vld0(ipkt_vld[0]), .ipkt_vld1(ipkt_vld[1]), .ipkt_vld2(ipkt_vld[2]),
    .ipkt_vld3(ipkt_vld[3]), .ipkt_vld4(ipkt_vld[4]), .ipkt_vld5(ipkt_vld[5]),
    .ipkt_vld6(ipkt_vld[6]), .ipkt_vld7(ipkt_vld[7]),
    .frm_colour(frm_colour), .frm_seq(frm_seq), .frm_vld(frm_vld),
    .ooc_colour(ooc_colour), .ooc_vld(ooc_vld), .reg_frme(reg_frme), .reg_crce(reg_crce)
  );

  // Reference CRC-16-CCITT, word consumed from bit 31 downwards.
  function automatic logic [15:0] crcWord(input logic [15:0] c, input logic [31:0] w);
    logic [15:0] r;
    logic [31:0] s;
    r = c;
    s = w;
    repeat (32) begin
      r = (r << 1) ^ ((r[15] ^ s[31]) ? 16'h1021 : 16'h0000);
      s = s << 1;
    end
    return r;
  endfunction

  // One valid word, then optional idle cycles carrying SOF-like junk that must be ignored.
  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input int stall);
    hsl_data = d;
    hsl_kchr = k;
    hsl_vld  = 1'b1;
    @(posedge clk);
    #1;
    hsl_vld = 1'b0;
    for (int i = 0; i < stall; i++) begin
      hsl_data = 32'h0000_01BC;
      hsl_kchr = 4'b0001;
      @(posedge clk);
      #1;
    end
    hsl_kchr = 4'b0000;
  endtask

  task automatic idleCycle();
    hsl_vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic sendHeader(input logic [7:0] ftype, input logic [7:0] bmp,
                            input logic [6:0] seq, input logic colour, input int stall);
    logic [31:0] w;
    w = {ftype, colour, seq, bmp, 8'hBC};
    run_crc = crcWord(16'hFFFF, w);
    applyStimulus(w, 4'b0001, stall);
  endtask

  task automatic sendPkt(input int ch, input int stall);
    logic [31:0] w [3];
    w[0] = pkts[ch][31:0];
    w[1] = pkts[ch][63:32];
    w[2] = {24'h3C5AA5, pkts[ch][71:64]};
    for (int i = 0; i < 3; i++) begin
      run_crc = crcWord(run_crc, w[i]);
      applyStimulus(w[i], 4'b0000, stall);
    end
  endtask

  task automatic sendBody(input logic [7:0] ftype, input logic [7:0] bmp,
                          input logic [6:0] seq, input logic colour, input int stall);
    sendHeader(ftype, bmp, seq, colour, stall);
    for (int ch = 0; ch < 8; ch++) begin
      if (bmp[ch]) sendPkt(ch, stall);
    end
  endtask

  task automatic sendTrailer(input logic [15:0] crc_xor);
    applyStimulus({8'hFD, 8'h00, run_crc ^ crc_xor}, 4'b1000, 0);
  endtask

  task automatic checkOutput(input string tag, input logic [71:0] observed,
                             input logic [71:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkCommit(input string tag, input logic e_frm, input logic e_ooc,
                             input logic [7:0] e_mask, input logic [6:0] e_seq,
                             input logic e_col, input logic e_frme, input logic e_crce);
    checkOutput({tag, ".frm_vld"}, 72'(frm_vld), 72'(e_frm));
    checkOutput({tag, ".ooc_vld"}, 72'(ooc_vld), 72'(e_ooc));
    checkOutput({tag, ".ipkt_vld"}, 72'(ipkt_vld), 72'(e_mask));
    checkOutput({tag, ".reg_frme"}, 72'(reg_frme), 72'(e_frme));
    checkOutput({tag, ".reg_crce"}, 72'(reg_crce), 72'(e_crce));
    if (e_frm) begin
      checkOutput({tag, ".frm_seq"}, 72'(frm_seq), 72'(e_seq));
      checkOutput({tag, ".frm_colour"}, 72'(frm_colour), 72'(e_col));
    end
    if (e_ooc) checkOutput({tag, ".ooc_colour"}, 72'(ooc_colour), 72'(e_col));
    for (int i = 0; i < 8; i++) begin
      if (e_mask[i]) checkOutput($sformatf("%s.data%0d", tag, i), ipkt_data[i], pkts[i]);
    end
  endtask

  initial begin
    pkts[0] = 72'h11_2233_4455_6677_8899;
    pkts[1] = 72'hC3_0F0F_0F0F_F0F0_F0F0;
    pkts[2] = 72'hAB_CDEF_0123_4567_89AB;
    pkts[3] = 72'h00;
    pkts[4] = 72'h00;
    pkts[5] = 72'h00;
    pkts[6] = 72'h00;
    pkts[7] = 72'h7E_DEAD_BEEF_CAFE_F00D;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    checkCommit("reset", 1'b0, 1'b0, 8'h00, 7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.frm_seq", 72'(frm_seq), 72'd0);
    checkOutput("reset.ipkt_data0", ipkt_data[0], 72'd0);
    rst = 1'b0;
    idleCycle();

    $display("[TB] data frame bitmap 05");
    sendBody(8'h00, 8'h05, 7'd3, 1'b1, 0);
    sendTrailer(16'h0000);
    checkCommit("frame1", 1'b1, 1'b0, 8'h05, 7'd3, 1'b1, 1'b0, 1'b0);
    idleCycle();
    checkCommit("frame1_after", 1'b0, 1'b0, 8'h00, 7'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] same frame with 5-cycle stalls");
    sendBody(8'h00, 8'h05, 7'd3, 1'b1, 5);
    checkOutput("stall.no_early_commit", 72'(frm_vld), 72'd0);
    sendTrailer(16'h0000);
    checkCommit("stall", 1'b1, 1'b0, 8'h05, 7'd3, 1'b1, 1'b0, 1'b0);

    $display("[TB] back-to-back OOC frames");
    sendBody(8'h01, 8'h00, 7'd5, 1'b1, 0);
    sendTrailer(16'h0000);
    checkCommit("ooc1", 1'b0, 1'b1, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0);
    sendHeader(8'h01, 8'h00, 7'd6, 1'b0, 0);
    checkCommit("ooc2_hdr", 1'b0, 1'b0, 8'h00, 7'd0, 1'b0, 1'b0, 1'b0);
    sendTrailer(16'h0000);
    checkCommit("ooc2", 1'b0, 1'b1, 8'h00, 7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ooc2.data0_stable", ipkt_data[0], pkts[0]);

    $display("[TB] corrupted CRC field");
    sendBody(8'h00, 8'h02, 7'd9, 1'b0, 0);
    sendTrailer(16'h0001);
`ifdef SPIO_HSS_MULTIPLEXER_RX_CRC_EN
    checkCommit("crc_bad", 1'b0, 1'b0, 8'h00, 7'd0, 1'b0, 1'b0, 1'b1);
`else
    checkCommit("crc_bad", 1'b1, 1'b0, 8'h02, 7'd9, 1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] SOF abort after word B");
    sendHeader(8'h00, 8'h01, 7'd1, 1'b0, 0);
    applyStimulus(32'hDEAD_DEAD, 4'b0000, 0);
    applyStimulus(32'hBEEF_BEEF, 4'b0000, 0);
    sendHeader(8'h00, 8'h80, 7'h55, 1'b1, 0);
    checkCommit("abort_sof", 1'b0, 1'b0, 8'h00, 7'd0, 1'b0, 1'b1, 1'b0);
    sendPkt(7, 0);
    sendTrailer(16'h0000);
    checkCommit("abort_next", 1'b1, 1'b0, 8'h80, 7'h55, 1'b1, 1'b0, 1'b0);
    checkOutput("abort_next.data0_stable", ipkt_data[0], pkts[0]);

    $display("[TB] unknown type then garbage");
    sendHeader(8'h7F, 8'h00, 7'd2, 1'b0, 0);
    checkCommit("bad_type", 1'b0, 1'b0, 8'h00, 7'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h1234_5678, 4'b0000, 0);
    applyStimulus(32'h0000_00AA, 4'b0001, 0);
    applyStimulus({8'hFD, 8'h00, 16'h1234}, 4'b1000, 0);
    checkCommit("garbage", 1'b0, 1'b0, 8'h00, 7'd0, 1'b0, 1'b0, 1'b0);
    sendBody(8'h00, 8'h00, 7'h7F, 1'b0, 0);
    sendTrailer(16'h0000);
    checkCommit("empty_frame", 1'b1, 1'b0, 8'h00, 7'h7F, 1'b0, 1'b0, 1'b0);

    $display("[TB] bad EOF code and K-char in packet");
    sendHeader(8'h00, 8'h00, 7'd4, 1'b1, 0);
    applyStimulus({8'hFE, 8'h00, run_crc}, 4'b1000, 0);
    checkCommit("bad_eof", 1'b0, 1'b0, 8'h00, 7'd0, 1'b0, 1'b1, 1'b0);
    sendHeader(8'h00, 8'h02, 7'd8, 1'b0, 0);
    applyStimulus(32'h0000_0000, 4'b0100, 0);
    checkCommit("kchr_pkt", 1'b0, 1'b0, 8'h00, 7'd0, 1'b0, 1'b1, 1'b0);
    sendBody(8'h00, 8'h02, 7'd10, 1'b1, 0);
    sendTrailer(16'h0000);
    checkCommit("recover", 1'b1, 1'b0, 8'h02, 7'd10, 1'b1, 1'b0, 1'b0);

    idleCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
